// File: rtl/pong_pkg.sv
// Shared Pong datapath constants: visible timing, hit-vector bit positions
// and the collision detector state encoding.
package pong_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int HIT_W       = 6;
  localparam int HIT_TOP     = 0;
  localparam int HIT_BOTTOM  = 1;
  localparam int HIT_PADDLE1 = 2;
  localparam int HIT_PADDLE2 = 3;
  localparam int HIT_GOAL_L  = 4;
  localparam int HIT_GOAL_R  = 5;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    SCAN      = 2'd1,
    PUBLISH   = 2'd2,
    HOLD      = 2'd3
  } cd_state_e;

endpackage

// File: rtl/collision_detect_if.sv
// Pixel-stream and result bundle between the sync/mask sources and the
// collision detector; also carries the detector state for observation.
interface collision_detect_if;
  import pong_pkg::*;

  // No valid/ready: one pixel per clock, never stalled. The masks describe
  // the pixel whose hcount/vcount were presented one clock earlier.
  logic [9:0]       hcount;
  logic [9:0]       vcount;
  logic             ball_on;
  logic             paddle1_on;
  logic             paddle2_on;
  logic             collision;
  logic [HIT_W-1:0] hit;
  logic [7:0]       frame_hits;
  cd_state_e        state;

  modport master (
    output hcount, vcount, ball_on, paddle1_on, paddle2_on,
    input  collision, hit, frame_hits, state
  );

  modport slave (
    input  hcount, vcount, ball_on, paddle1_on, paddle2_on,
    output collision, hit, frame_hits, state
  );

endinterface

// File: rtl/region_decode.sv
// Combinational map of a screen coordinate onto the visible area and the
// wall/goal bands; shared with the renderer.
module region_decode #(
  parameter int H_ACTIVE    = pong_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = pong_pkg::V_ACTIVE,
  parameter int WALL_TOP    = 8,
  parameter int WALL_BOTTOM = 472,
  parameter int GOAL_LEFT   = 4,
  parameter int GOAL_RIGHT  = 636
) (
  input  logic [9:0] hd,
  input  logic [9:0] vd,
  output logic       active,
  output logic       top,
  output logic       bottom,
  output logic       goal_l,
  output logic       goal_r
);

  localparam logic [9:0] H_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_END  = 10'(V_ACTIVE);
  localparam logic [9:0] TOP_E  = 10'(WALL_TOP);
  localparam logic [9:0] BOT_S  = 10'(WALL_BOTTOM);
  localparam logic [9:0] GL_E   = 10'(GOAL_LEFT);
  localparam logic [9:0] GR_S   = 10'(GOAL_RIGHT);

  assign active = (hd < H_END) && (vd < V_END);
  assign top    = (vd < TOP_E);
  assign bottom = (vd >= BOT_S);
  assign goal_l = (hd < GL_E);
  assign goal_r = (hd >= GR_S);

endmodule

// File: rtl/collision_detect.sv
// Per-frame collision detector: accumulates ball contacts during the active
// scan and publishes a held hit vector at the start of vertical blanking.
module collision_detect #(
  parameter int H_ACTIVE    = pong_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = pong_pkg::V_ACTIVE,
  parameter int WALL_TOP    = 8,
  parameter int WALL_BOTTOM = 472,
  parameter int GOAL_LEFT   = 4,
  parameter int GOAL_RIGHT  = 636
) (
  input  logic               clk,
  input  logic               reset_n,
  collision_detect_if.slave  bus
);
  import pong_pkg::*;

  localparam logic [9:0] V_END = 10'(V_ACTIVE);

  logic [9:0]       hd;
  logic [9:0]       vd;
  logic             coord_valid;
  logic             in_active;
  logic             in_top;
  logic             in_bottom;
  logic             in_goal_l;
  logic             in_goal_r;
  logic [HIT_W-1:0] pix_bits;
  logic [HIT_W-1:0] acc;
  logic [HIT_W-1:0] acc_next;
  logic [HIT_W-1:0] hit_q;
  logic             collision_q;
  logic [7:0]       frame_hits_q;
  logic             load;
  logic             frame_origin;
  logic             publish_pt;
  cd_state_e        state;
  cd_state_e        state_next;

  // coord_valid keeps the reset value of hd/vd (0,0) from posing as a
  // frame origin, so a partial frame after reset is never accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hd          <= '0;
      vd          <= '0;
      coord_valid <= 1'b0;
    end else begin
      hd          <= bus.hcount;
      vd          <= bus.vcount;
      coord_valid <= 1'b1;
    end
  end

  region_decode #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .WALL_TOP    (WALL_TOP),
    .WALL_BOTTOM (WALL_BOTTOM),
    .GOAL_LEFT   (GOAL_LEFT),
    .GOAL_RIGHT  (GOAL_RIGHT)
  ) u_region (
    .hd     (hd),
    .vd     (vd),
    .active (in_active),
    .top    (in_top),
    .bottom (in_bottom),
    .goal_l (in_goal_l),
    .goal_r (in_goal_r)
  );

  always_comb begin
    pix_bits              = '0;
    pix_bits[HIT_TOP]     = in_top;
    pix_bits[HIT_BOTTOM]  = in_bottom;
    pix_bits[HIT_PADDLE1] = bus.paddle1_on;
    pix_bits[HIT_PADDLE2] = bus.paddle2_on;
    pix_bits[HIT_GOAL_L]  = in_goal_l;
    pix_bits[HIT_GOAL_R]  = in_goal_r;
  end

  assign frame_origin = coord_valid && (hd == 10'd0) && (vd == 10'd0);
  assign publish_pt   = (hd == 10'd0) && (vd == V_END);

  // The results register on the edge that enters PUBLISH, which lands them
  // two clocks after vcount reaches V_ACTIVE.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    load       = 1'b0;
    case (state)
      SYNC_WAIT: begin
        if (frame_origin) state_next = SCAN;
      end
      SCAN: begin
        if (frame_origin) begin
          acc_next = '0;
        end else if (publish_pt) begin
          state_next = PUBLISH;
          load       = 1'b1;
          acc_next   = '0;
        end else if (bus.ball_on && in_active) begin
          acc_next = acc | pix_bits;
        end
      end
      PUBLISH: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (frame_origin) state_next = SCAN;
      end
      default: begin
        state_next = SYNC_WAIT;
        acc_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SYNC_WAIT;
      acc   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q        <= '0;
      collision_q  <= 1'b0;
      frame_hits_q <= '0;
    end else if (load) begin
      hit_q       <= acc;
      collision_q <= |acc;
      if ((|acc) && (frame_hits_q != 8'hFF)) frame_hits_q <= frame_hits_q + 8'd1;
    end
  end

  assign bus.hit        = hit_q;
  assign bus.collision  = collision_q;
  assign bus.frame_hits = frame_hits_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_collision_detect.sv
// Frame-level bench for collision_detect on a reduced screen geometry.
module tb_collision_detect;
  import pong_pkg::*;

  localparam int HA = 12;
  localparam int VA = 10;
  localparam int WT = 2;
  localparam int WB = 8;
  localparam int GL = 2;
  localparam int GR = 10;
  localparam int HT = 14;
  localparam int VT = 13;

  logic       clk;
  logic       reset_n;
  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_hit;
  logic       exp_coll;
  logic [7:0] exp_cnt;
  bit         ball_m [VT][HT];
  bit         p1_m   [VT][HT];
  bit         p2_m   [VT][HT];
  bit         pb, pp1, pp2;

  collision_detect_if bus ();

  collision_detect #(
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA),
    .WALL_TOP    (WT),
    .WALL_BOTTOM (WB),
    .GOAL_LEFT   (GL),
    .GOAL_RIGHT  (GR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_hit"},        32'(bus.hit),        32'(exp_hit));
    check({tag, "_collision"},  32'(bus.collision),  32'(exp_coll));
    check({tag, "_frame_hits"}, 32'(bus.frame_hits), 32'(exp_cnt));
  endtask

  // Reference: OR of the region/paddle flags of every visible ball pixel.
  function automatic logic [5:0] model_hits();
    logic [5:0] h = '0;
    for (int r = 0; r < VA; r++)
      for (int c = 0; c < HA; c++)
        if (ball_m[r][c]) begin
          if (r < WT)     h[HIT_TOP]     = 1'b1;
          if (r >= WB)    h[HIT_BOTTOM]  = 1'b1;
          if (p1_m[r][c]) h[HIT_PADDLE1] = 1'b1;
          if (p2_m[r][c]) h[HIT_PADDLE2] = 1'b1;
          if (c < GL)     h[HIT_GOAL_L]  = 1'b1;
          if (c >= GR)    h[HIT_GOAL_R]  = 1'b1;
        end
    return h;
  endfunction

  task automatic clear_masks();
    for (int r = 0; r < VT; r++)
      for (int c = 0; c < HT; c++) begin
        ball_m[r][c] = 1'b0;
        p1_m[r][c]   = 1'b0;
        p2_m[r][c]   = 1'b0;
      end
  endtask

  task automatic set_px(input int r, input int c, input bit b, input bit p1, input bit p2);
    ball_m[r][c] = b;
    p1_m[r][c]   = p1;
    p2_m[r][c]   = p2;
  endtask

  // Drives `rows` scan lines; rst_row >= 0 pulses reset inside that row.
  task automatic run_frame(input int rows, input int rst_row);
    bit         rst_seen = 1'b0;
    logic [5:0] h;
    if (rows > VA) exp_q.push_back(model_hits());
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < HT; c++) begin
        @(negedge clk);
        if (r == VA && c == 1) check_outputs("pre_publish");
        if (r == VA && c == 2) begin
          h = exp_q.pop_front();
          if (!rst_seen) begin
            exp_hit  = h;
            exp_coll = |h;
            if (exp_coll && exp_cnt != 8'hFF) exp_cnt++;
          end
          check_outputs("publish");
          check("state_publish", 32'(bus.state), 32'(rst_seen ? SYNC_WAIT : PUBLISH));
        end
        if (r == VA && c == 3)
          check("state_hold", 32'(bus.state), 32'(rst_seen ? SYNC_WAIT : HOLD));
        if (r == VT - 1 && c == HT - 1) check_outputs("hold");
        bus.hcount     = 10'(c);
        bus.vcount     = 10'(r);
        bus.ball_on    = pb;
        bus.paddle1_on = pp1;
        bus.paddle2_on = pp2;
        pb  = ball_m[r][c];
        pp1 = p1_m[r][c];
        pp2 = p2_m[r][c];
        if (r == rst_row && c == 4) begin
          reset_n = 1'b0;
          #1;
          rst_seen = 1'b1;
          exp_hit  = '0;
          exp_coll = 1'b0;
          exp_cnt  = '0;
          check_outputs("async_reset");
          check("state_reset", 32'(bus.state), 32'(SYNC_WAIT));
        end
        if (r == rst_row && c == 7) reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.hcount     = 10'(HT - 2);
    bus.vcount     = 10'(VT - 1);
    bus.ball_on    = 1'b0;
    bus.paddle1_on = 1'b0;
    bus.paddle2_on = 1'b0;
    pb = 1'b0; pp1 = 1'b0; pp2 = 1'b0;
    exp_hit = '0; exp_coll = 1'b0; exp_cnt = '0;
    clear_masks();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("por");
    check("state_por", 32'(bus.state), 32'(SYNC_WAIT));
    @(negedge clk);
    reset_n = 1'b1;

    // clean frame: ball in open field only
    clear_masks();
    set_px(5, 6, 1, 0, 0);
    run_frame(VT, -1);

    // top wall, five consecutive pixels
    clear_masks();
    for (int c = 3; c < 8; c++) set_px(1, c, 1, 0, 0);
    run_frame(VT, -1);

    // paddle1 and bottom wall in one frame
    clear_masks();
    set_px(4, 3, 1, 1, 0);
    set_px(9, 3, 1, 0, 0);
    run_frame(VT, -1);

    // quiet frame clears the flags, count stays
    clear_masks();
    run_frame(VT, -1);

    // last visible pixel: bottom wall and right goal
    clear_masks();
    set_px(VA - 1, HA - 1, 1, 0, 0);
    run_frame(VT, -1);

    // ball only in vertical and horizontal blanking
    clear_masks();
    for (int r = VA; r < VT; r++)
      for (int c = 0; c < HT; c++) set_px(r, c, 1, 1, 1);
    for (int r = 1; r < VA; r++) set_px(r, HA, 1, 1, 1);
    run_frame(VT, -1);

    // reset mid-frame with a pending hit, then a normal frame
    clear_masks();
    set_px(1, 3, 1, 0, 0);
    set_px(6, 5, 1, 1, 0);
    run_frame(VT, 3);
    run_frame(VT, -1);

    // vcount wraps early: the short frame's hit is dropped
    clear_masks();
    set_px(1, 4, 1, 0, 0);
    run_frame(5, -1);
    clear_masks();
    set_px(8, 5, 1, 0, 0);
    run_frame(VT, -1);

    // randomized frames
    for (int f = 0; f < 15; f++) begin
      clear_masks();
      for (int r = 0; r < VT; r++)
        for (int c = 0; c < HT; c++)
          if (!(r == 0 && c == 0))
            set_px(r, c, $urandom_range(0, 29) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      run_frame(VT, -1);
    end

    // saturation of the frame counter
    clear_masks();
    set_px(5, 6, 1, 0, 1);
    for (int f = 0; f < 260; f++) run_frame(VT, -1);
    @(negedge clk);
    check("sat_count", 32'(bus.frame_hits), 32'd255);
    check("sat_hit", 32'(bus.hit), 32'h08);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
